// File: rtl/axi_burst_slave_pkg.sv
// Shared definitions for the AXI-style burst slave: field widths,
// response codes, FSM state enums and the request field layout.
package axi_mini_pkg;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 4;
    localparam int ID_W   = 4;
    localparam int DATA_W = 8;
    localparam int SUM_W  = ADDR_W + 1;

    localparam logic OKAY = 1'b0;
    localparam logic ERR  = 1'b1;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    // Request word layout shared by AR and AW: {addr, len, id}
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
    } req_t;

    // Beat address with one carry bit so crossing 0xFF is visible.
    function automatic logic [SUM_W-1:0] beat_sum(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  beat);
        return SUM_W'(base) + SUM_W'(beat);
    endfunction

endpackage

// File: rtl/axi_burst_slave_if.sv
// Bus bundle for the burst slave: AR, R, AW, W and B channels.
// Handshake rule for every channel: a transfer happens at a rising edge
// where VALID and READY are both 1; a source holds VALID and its payload
// stable until that edge, and READY may rise or fall freely.
interface axi_burst_slave_if;
    import axi_mini_pkg::*;

    logic                          ARVALID;
    logic                          ARREADY;
    logic [ADDR_W+LEN_W+ID_W-1:0]  ARIN;

    logic                          RVALID;
    logic                          RREADY;
    logic                          RLAST;
    logic [DATA_W:0]               ROUT;

    logic                          AWVALID;
    logic                          AWREADY;
    logic [ADDR_W+LEN_W+ID_W-1:0]  AWIN;

    logic                          WVALID;
    logic                          WREADY;
    logic [DATA_W-1:0]             WDATA;
    logic                          WLAST;

    logic                          BVALID;
    logic                          BREADY;
    logic [ID_W:0]                 BOUT;

    modport slave (
        input  ARVALID, ARIN, RREADY, AWVALID, AWIN, WVALID, WDATA, WLAST, BREADY,
        output ARREADY, RVALID, RLAST, ROUT, AWREADY, WREADY, BVALID, BOUT
    );

    modport master (
        output ARVALID, ARIN, RREADY, AWVALID, AWIN, WVALID, WDATA, WLAST, BREADY,
        input  ARREADY, RVALID, RLAST, ROUT, AWREADY, WREADY, BVALID, BOUT
    );

endinterface

// File: rtl/axi_burst_slave_mem.sv
// Byte storage for the burst slave: one synchronous write port and one
// registered read port. A read and write of the same location in one
// cycle returns the old contents. Only the read register is reset.
module slave_mem #(
    parameter  int MEM_DEPTH = 256,
    localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [MEM_DEPTH];
    logic [7:0] rdata_q;

    // Write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register only updates when a new beat is fetched, so it holds under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_burst_slave.sv
// Burst slave with independent read and write FSMs over a byte memory.
// Optional macro AXI_SLAVE_BOUNDARY_ERR_EN: beats past address 255 or
// MEM_DEPTH-1 are suppressed and flagged with an error response; without
// it beat addresses simply wrap.
module axi_burst_slave
    import axi_mini_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_burst_slave_if.slave     bus,
    output r_state_e             dbg_r_state_o,
    output w_state_e             dbg_w_state_o,
    output logic [ID_W-1:0]      dbg_r_id_o
);

    localparam int               IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [SUM_W-1:0] LAST_IDX = SUM_W'(MEM_DEPTH - 1);
`ifdef AXI_SLAVE_BOUNDARY_ERR_EN
    localparam logic             BOUND_CHECK = 1'b1;
`else
    localparam logic             BOUND_CHECK = 1'b0;
`endif

    // A beat is out of range only when boundary checking is built in.
    function automatic logic beat_oob(input logic [SUM_W-1:0] sum);
        return BOUND_CHECK && (sum > LAST_IDX);
    endfunction

    req_t ar_req;
    req_t aw_req;
    assign ar_req = req_t'(bus.ARIN);
    assign aw_req = req_t'(bus.AWIN);

    // ---------------- read channel state ----------------
    r_state_e          r_state_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [LEN_W-1:0]  r_len_q;
    logic [LEN_W-1:0]  r_beat_q;
    logic [LEN_W-1:0]  r_beat_d;
    logic [ID_W-1:0]   r_id_q;
    logic              arready_q;
    logic              rvalid_q;
    logic              rlast_q;
    logic              rerr_q;

    logic              ar_fire;
    logic              r_fire;
    logic              mem_re;
    logic [SUM_W-1:0]  rd_sum;
    logic [7:0]        mem_rdata;

    assign ar_fire  = (r_state_q == R_IDLE) && arready_q && bus.ARVALID;
    assign r_fire   = (r_state_q == R_DATA) && rvalid_q && bus.RREADY;
    assign r_beat_d = r_beat_q + LEN_W'(1);
    assign mem_re   = ar_fire || (r_fire && !rlast_q);

    // Address of the beat to fetch: first beat on AR accept, otherwise the next beat.
    always_comb begin
        rd_sum = beat_sum(r_addr_q, r_beat_d);
        if (ar_fire) begin
            rd_sum = beat_sum(ar_req.addr, LEN_W'(0));
        end
    end

    // Read FSM: accept AR, then stream len+1 beats with registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_id_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rerr_q    <= OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_fire) begin
                        r_addr_q  <= ar_req.addr;
                        r_len_q   <= ar_req.len;
                        r_id_q    <= ar_req.id;
                        r_beat_q  <= '0;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (ar_req.len == '0);
                        rerr_q    <= beat_oob(rd_sum);
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rerr_q    <= OKAY;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_beat_q <= r_beat_d;
                            rlast_q  <= (r_beat_d == r_len_q);
                            rerr_q   <= beat_oob(rd_sum);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel state ----------------
    w_state_e          w_state_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [LEN_W-1:0]  w_len_q;
    logic [LEN_W-1:0]  w_beat_q;
    logic [ID_W-1:0]   w_id_q;
    logic              werr_q;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [ID_W:0]     bout_q;

    logic              aw_fire;
    logic              w_fire;
    logic              w_last_beat;
    logic              w_beat_err;
    logic              mem_we;
    logic [SUM_W-1:0]  wr_sum;

    assign aw_fire     = (w_state_q == W_IDLE) && awready_q && bus.AWVALID;
    assign w_fire      = (w_state_q == W_DATA) && wready_q && bus.WVALID;
    assign wr_sum      = beat_sum(w_addr_q, w_beat_q);
    assign w_last_beat = (w_beat_q == w_len_q);
    assign w_beat_err  = (bus.WLAST != w_last_beat) || beat_oob(wr_sum);
    assign mem_we      = w_fire && !beat_oob(wr_sum) && !rst;

    // Write FSM: accept AW, take exactly len+1 beats, then hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_id_q    <= '0;
            werr_q    <= OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bout_q    <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_fire) begin
                        w_addr_q  <= aw_req.addr;
                        w_len_q   <= aw_req.len;
                        w_id_q    <= aw_req.id;
                        w_beat_q  <= '0;
                        werr_q    <= OKAY;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_last_beat) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bout_q    <= {w_id_q, werr_q | w_beat_err};
                            w_state_q <= W_RESP;
                        end else begin
                            w_beat_q <= w_beat_q + LEN_W'(1);
                            werr_q   <= werr_q | w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        bvalid_q  <= 1'b0;
                        bout_q    <= '0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    slave_mem #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (wr_sum[IDX_W-1:0]),
        .wdata_i (bus.WDATA),
        .re_i    (mem_re),
        .raddr_i (rd_sum[IDX_W-1:0]),
        .rdata_o (mem_rdata)
    );

    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RLAST   = rlast_q;
    assign bus.ROUT    = {(rerr_q ? 8'h00 : mem_rdata), rerr_q};
    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BOUT    = bout_q;

    assign dbg_r_state_o = r_state_q;
    assign dbg_w_state_o = w_state_q;
    assign dbg_r_id_o    = r_id_q;

endmodule

// File: tb/tb_axi_burst_slave.sv
// Directed bench for axi_burst_slave with a small memory model and
// scoreboard queues for read beats and write responses.
module tb_axi_burst_slave;
    import axi_mini_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_burst_slave_if bus ();
    r_state_e   dbg_r_state;
    w_state_e   dbg_w_state;
    logic [3:0] dbg_r_id;

    axi_burst_slave #(.MEM_DEPTH(256)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .dbg_r_state_o (dbg_r_state),
        .dbg_w_state_o (dbg_w_state),
        .dbg_r_id_o    (dbg_r_id)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] model_mem [256];
    logic [9:0] exp_q [$];     // {last, data, resp}
    logic [4:0] b_exp_q [$];   // {id, resp}

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic beat_oob(input logic [7:0] addr, input int i);
`ifdef AXI_SLAVE_BOUNDARY_ERR_EN
        return (int'(addr) + i) > 255;
`else
        return 1'b0;
`endif
    endfunction

    task automatic write_burst(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                               input logic [7:0] data [16], input int wlast_beat);
        logic       resp;
        int         guard;
        logic [4:0] exp_b;
        resp = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if ((i == wlast_beat) != (i == int'(len))) resp = 1'b1;
            if (beat_oob(addr, i)) resp = 1'b1;
        end
        b_exp_q.push_back({id, resp});
        bus.AWVALID = 1'b1;
        bus.AWIN    = {addr, len, id};
        guard = 0;
        while (bus.AWREADY !== 1'b1 && guard < 50) begin tick(); guard++; end
        check("awready_wait", 16'(bus.AWREADY), 16'd1);
        tick();
        bus.AWVALID = 1'b0;
        bus.AWIN    = '0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.WVALID = 1'b1;
            bus.WDATA  = data[i];
            bus.WLAST  = (i == wlast_beat);
            guard = 0;
            while (bus.WREADY !== 1'b1 && guard < 50) begin tick(); guard++; end
            check("wready_wait", 16'(bus.WREADY), 16'd1);
            tick();
            if (!beat_oob(addr, i)) model_mem[8'(int'(addr) + i)] = data[i];
            if (i != int'(len)) check("bvalid_early", 16'(bus.BVALID), 16'd0);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        exp_b = b_exp_q.pop_front();
        check("bvalid", 16'(bus.BVALID), 16'd1);
        check("bout", 16'(bus.BOUT), 16'(exp_b));
        tick();
        check("bout_hold", 16'({bus.BVALID, bus.BOUT}), 16'({1'b1, exp_b}));
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        check("bvalid_clear", 16'(bus.BVALID), 16'd0);
        check("awready_back", 16'(bus.AWREADY), 16'd1);
    endtask

    task automatic read_burst(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                              input int stall_beat, input int stall_cycles);
        int         guard;
        logic [9:0] e;
        logic [7:0] d;
        for (int i = 0; i <= int'(len); i++) begin
            d = beat_oob(addr, i) ? 8'h00 : model_mem[8'(int'(addr) + i)];
            exp_q.push_back({(i == int'(len)), d, beat_oob(addr, i)});
        end
        bus.ARVALID = 1'b1;
        bus.ARIN    = {addr, len, id};
        guard = 0;
        while (bus.ARREADY !== 1'b1 && guard < 50) begin tick(); guard++; end
        check("arready_wait", 16'(bus.ARREADY), 16'd1);
        tick();
        bus.ARVALID = 1'b0;
        bus.ARIN    = '0;
        check("rvalid_latency", 16'(bus.RVALID), 16'd1);
        check("r_id", 16'(dbg_r_id), 16'(id));
        for (int i = 0; i <= int'(len); i++) begin
            e = exp_q.pop_front();
            check("r_beat", 16'({bus.RVALID, bus.RLAST, bus.ROUT}), 16'({1'b1, e}));
            if (i == stall_beat) begin
                for (int c = 0; c < stall_cycles; c++) begin
                    tick();
                    check("r_hold", 16'({bus.RVALID, bus.RLAST, bus.ROUT}), 16'({1'b1, e}));
                end
            end
            bus.RREADY = 1'b1;
            tick();
            bus.RREADY = 1'b0;
        end
        check("rvalid_clear", 16'(bus.RVALID), 16'd0);
        check("arready_back", 16'(bus.ARREADY), 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wd [16];
        logic [7:0] ra;
        logic [3:0] rl;

        // Clock/reset and idle inputs
        rst = 1'b1;
        bus.ARVALID = 1'b0; bus.ARIN = '0; bus.RREADY = 1'b0;
        bus.AWVALID = 1'b0; bus.AWIN = '0; bus.WVALID = 1'b0;
        bus.WDATA = '0; bus.WLAST = 1'b0; bus.BREADY = 1'b0;
        for (int i = 0; i < 16; i++) wd[i] = 8'h00;
        repeat (3) tick();
        check("rst_flags", 16'({bus.ARREADY, bus.AWREADY, bus.RVALID, bus.RLAST, bus.WREADY, bus.BVALID}), 16'd0);
        check("rst_rout", 16'(bus.ROUT), 16'd0);
        check("rst_bout", 16'(bus.BOUT), 16'd0);
        rst = 1'b0;
        tick();
        check("arready_after_rst", 16'(bus.ARREADY), 16'd1);
        check("awready_after_rst", 16'(bus.AWREADY), 16'd1);

        // Four-beat write then read back with a two-cycle stall after beat 1
        wd[0] = 8'hA0; wd[1] = 8'hA1; wd[2] = 8'hA2; wd[3] = 8'hA3;
        write_burst(8'h10, 4'd3, 4'd5, wd, 3);
        read_burst(8'h10, 4'd3, 4'd2, 1, 2);

        // Single-beat read
        read_burst(8'h12, 4'd0, 4'd7, -1, 0);

        // Burst crossing the top of the address space
        wd[0] = 8'hC0; wd[1] = 8'hC1; wd[2] = 8'hC2; wd[3] = 8'hC3;
        write_burst(8'hFE, 4'd3, 4'd1, wd, 3);
        read_burst(8'hFE, 4'd3, 4'd4, -1, 0);

        // Early WLAST: burst still runs four beats and reports an error
        wd[0] = 8'h30; wd[1] = 8'h31; wd[2] = 8'h32; wd[3] = 8'h33;
        write_burst(8'h40, 4'd3, 4'd7, wd, 1);
        read_burst(8'h40, 4'd3, 4'd3, -1, 0);

        // Missing WLAST on a single-beat burst
        wd[0] = 8'h77;
        write_burst(8'h50, 4'd0, 4'd9, wd, -1);

        // Full-length random burst
        for (int i = 0; i < 16; i++) wd[i] = 8'($urandom_range(0, 255));
        write_burst(8'h80, 4'd15, 4'd12, wd, 15);
        read_burst(8'h80, 4'd15, 4'd13, 7, 1);

        // Random address/length burst
        ra = 8'($urandom_range(0, 255));
        rl = 4'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) wd[i] = 8'($urandom_range(0, 255));
        write_burst(ra, rl, 4'd6, wd, int'(rl));
        read_burst(ra, rl, 4'd8, 0, 1);

        // Re-establish 0x10..0x13 after the random burst may have touched them
        wd[0] = 8'hA0; wd[1] = 8'hA1; wd[2] = 8'hA2; wd[3] = 8'hA3;
        write_burst(8'h10, 4'd3, 4'd5, wd, 3);

        // Same-cycle read and write of 0x10: read sees the old byte
        check("pre_rw_ready", 16'({bus.ARREADY, bus.AWREADY}), 16'b11);
        bus.AWVALID = 1'b1; bus.AWIN = {8'h10, 4'd0, 4'd4};
        tick();
        bus.AWVALID = 1'b0; bus.AWIN = '0;
        bus.WVALID = 1'b1; bus.WDATA = 8'h5C; bus.WLAST = 1'b1;
        bus.ARVALID = 1'b1; bus.ARIN = {8'h10, 4'd0, 4'd6};
        tick();
        bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.ARVALID = 1'b0; bus.ARIN = '0;
        check("rw_same_read", 16'({bus.RVALID, bus.RLAST, bus.ROUT}), 16'({1'b1, 1'b1, 8'hA0, 1'b0}));
        check("rw_same_b", 16'({bus.BVALID, bus.BOUT}), 16'({1'b1, 4'd4, 1'b0}));
        bus.RREADY = 1'b1; bus.BREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0; bus.BREADY = 1'b0;
        model_mem[8'h10] = 8'h5C;
        read_burst(8'h10, 4'd0, 4'd6, -1, 0);

        // Reset in the middle of a read burst
        bus.ARVALID = 1'b1; bus.ARIN = {8'h10, 4'd3, 4'd9};
        tick();
        bus.ARVALID = 1'b0; bus.ARIN = '0;
        check("mid_read_beat0", 16'({bus.RVALID, bus.ROUT}), 16'({1'b1, 8'h5C, 1'b0}));
        rst = 1'b1;
        tick();
        check("mid_rst_rvalid", 16'({bus.RVALID, bus.RLAST, bus.ARREADY}), 16'd0);
        rst = 1'b0;
        tick();
        check("mid_rst_arready", 16'(bus.ARREADY), 16'd1);
        read_burst(8'h11, 4'd2, 4'd10, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
